mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter_starve_cnt.sv | 34 +++
 rtl/mem_arbiter.sv | 92 +++++++++
 tb/tb_mem_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_arbiter_pkg : shared widths, state encoding and types for mem_arbiter   |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_arbiter_pkg;

  localparam int ISIZE          = 16;
  localparam int DSIZE          = 16;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [0:0] {
    ARB_LOAD = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic if_rd;
    logic d_rd;
  } rd_tag_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | mem_arbiter_if : fetch, data and memory-side signals of the arbiter         |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mem_arbiter_if
  import mem_arbiter_pkg::*;
();

  logic             if_req;
  logic [ISIZE-1:0] if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [DSIZE-1:0] if_rdata;

  logic             d_req;
  logic             d_we;
  logic [ISIZE-1:0] d_addr;
  logic [DSIZE-1:0] d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [DSIZE-1:0] d_rdata;

  logic             mem_rst;
  logic             mem_wen;
  logic [ISIZE-1:0] mem_addr;
  logic [DSIZE-1:0] mem_wdata;
  logic [DSIZE-1:0] mem_rdata;

  logic             ready;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_rst, mem_wen, mem_addr, mem_wdata, ready
  );

  // Requesters and memory side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_rst, mem_wen, mem_addr, mem_wdata, ready
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_starve_cnt.sv
// +----------------------------------------------------------------------------+
// | arb_starve_cnt : saturating count of contended data grants (fair mode)      |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module arb_starve_cnt #(
  parameter int MAX = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic inc,
  input  wire logic clr,
  output logic      at_max
);

  localparam int CNT_W = $clog2(MAX + 1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign at_max = (r_cnt == C_MAX);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_arbiter : shares the single memory port between fetch and data, and     |
// | sequences the memory load after reset. MEM_ARB_FAIR_EN adds anti-starvation.|
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX  = STARVE_MAX_DEF,
  parameter int LOAD_CYCLES = 1
) (
  input wire logic     clk,
  input wire logic     rst_n,
  mem_arbiter_if.slave bus
);

  localparam int LOAD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [LOAD_W-1:0] C_LOAD_LAST = LOAD_W'(LOAD_CYCLES - 1);

  arb_state_e        r_state;
  logic [LOAD_W-1:0] r_load_cnt;
  logic              r_mem_rst;
  logic              r_ready;
  rd_tag_t           r_tag;

  logic w_run;
  logic w_d_gnt;
  logic w_if_gnt;
  logic w_at_max;

  // Reset takes effect on outputs in the very cycle it is asserted
  assign w_run = r_ready & rst_n;

`ifdef MEM_ARB_FAIR_EN
  arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (w_d_gnt & bus.if_req),
    .clr    (w_if_gnt | ~bus.if_req),
    .at_max (w_at_max)
  );
`else
  logic w_unused_starve;
  assign w_unused_starve = (STARVE_MAX != 0);
  assign w_at_max        = 1'b0;
`endif

  assign w_d_gnt  = w_run & bus.d_req & ~(bus.if_req & w_at_max);
  assign w_if_gnt = w_run & bus.if_req & ~w_d_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ARB_LOAD;
      r_load_cnt <= '0;
      r_mem_rst  <= 1'b1;
      r_ready    <= 1'b0;
      r_tag      <= '0;
    end else begin
      r_tag.if_rd <= w_if_gnt;
      r_tag.d_rd  <= w_d_gnt & ~bus.d_we;
      if (r_state == ARB_LOAD) begin
        if (r_load_cnt == C_LOAD_LAST) begin
          r_state   <= ARB_RUN;
          r_mem_rst <= 1'b0;
          r_ready   <= 1'b1;
        end else begin
          r_load_cnt <= r_load_cnt + LOAD_W'(1);
        end
      end
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.if_rvalid = r_tag.if_rd & rst_n;
  assign bus.d_rvalid  = r_tag.d_rd & rst_n;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

  assign bus.mem_rst   = r_mem_rst | ~rst_n;
  assign bus.ready     = w_run;
  assign bus.mem_wen   = w_d_gnt & bus.d_we;
  assign bus.mem_addr  = w_d_gnt ? bus.d_addr : bus.if_addr;
  assign bus.mem_wdata = bus.d_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter : directed plus random checks of mem_arbiter against a       |
// | cycle-level behavioural model with a stub memory.                           |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int SMAX = 4;
  localparam int LCYC = 1;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(
    .STARVE_MAX  (SMAX),
    .LOAD_CYCLES (LCYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [DSIZE-1:0] load_val(int i);
    return DSIZE'((i * 37) ^ 16'h5A5A);
  endfunction

  // Stub memory: registered read, write at the edge, reload while mem_rst
  logic [DSIZE-1:0] stub_mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_rst) begin
      for (int i = 0; i < 256; i++) stub_mem[i] <= load_val(i);
    end else if (bus.mem_wen) begin
      stub_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= stub_mem[bus.mem_addr[7:0]];
  end

  // Reference model state
  int               n_assert = 0;
  int               n_fail   = 0;
  int               hi_edges = 0;
  int               streak   = 0;
  bit               pend_if  = 1'b0;
  bit               pend_d   = 1'b0;
  logic [DSIZE-1:0] pend_data = '0;
  logic [DSIZE-1:0] ref_mem [0:255];
  bit               exp_ready, exp_d_g, exp_if_g;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    exp_ready = rst_n && (hi_edges >= LCYC);
    exp_d_g   = exp_ready && bus.d_req && !(FAIR && bus.if_req && streak == SMAX);
    exp_if_g  = exp_ready && bus.if_req && !exp_d_g;
    chk("ready",     32'(bus.ready),     32'(exp_ready));
    chk("mem_rst",   32'(bus.mem_rst),   32'(!exp_ready));
    chk("d_gnt",     32'(bus.d_gnt),     32'(exp_d_g));
    chk("if_gnt",    32'(bus.if_gnt),    32'(exp_if_g));
    chk("mem_wen",   32'(bus.mem_wen),   32'(exp_d_g && bus.d_we));
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(pend_if && rst_n));
    chk("d_rvalid",  32'(bus.d_rvalid),  32'(pend_d && rst_n));
    if (pend_if && rst_n) chk("if_rdata", 32'(bus.if_rdata), 32'(pend_data));
    if (pend_d && rst_n)  chk("d_rdata",  32'(bus.d_rdata),  32'(pend_data));
    if (exp_d_g || exp_if_g)
      chk("mem_addr", 32'(bus.mem_addr), 32'(exp_d_g ? bus.d_addr : bus.if_addr));
    if (exp_d_g && bus.d_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(bus.d_wdata));
    @(posedge clk);
    if (!rst_n) begin
      hi_edges = 0;
      streak   = 0;
      pend_if  = 1'b0;
      pend_d   = 1'b0;
    end else begin
      if (hi_edges < 1000) hi_edges++;
      pend_if = exp_if_g;
      pend_d  = exp_d_g && !bus.d_we;
      if (exp_if_g)    pend_data = ref_mem[bus.if_addr[7:0]];
      else if (pend_d) pend_data = ref_mem[bus.d_addr[7:0]];
      if (exp_d_g && bus.d_we) ref_mem[bus.d_addr[7:0]] = bus.d_wdata;
      if (exp_if_g || !bus.if_req) streak = 0;
      else if (exp_d_g && streak < SMAX) streak++;
    end
    if (!exp_ready) for (int i = 0; i < 256; i++) ref_mem[i] = load_val(i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  int if_grants;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = load_val(i);
    idle_inputs();
    rst_n = 1'b0;

    // Reset held for three cycles
    repeat (3) cycle();

    // Release with a fetch already waiting: no grant during load
    rst_n       = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0004;
    cycle();
    cycle();

    // Fetch response, together with a data write
    bus.if_req  = 1'b0;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0010;
    bus.d_wdata = 16'hBEEF;
    cycle();

    // Read back the written word
    bus.d_we    = 1'b0;
    bus.d_wdata = '0;
    cycle();
    idle_inputs();
    cycle();

    // Continuous contention
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0008;
    bus.d_req   = 1'b1;
    bus.d_addr  = 16'h0020;
    if_grants   = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (exp_if_g) if_grants++;
    end
    chk("contention_if_grants", 32'(if_grants), FAIR ? 32'd3 : 32'd0);
    idle_inputs();
    cycle();

    // Random traffic with occasional resets; requests held until granted
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      if (!bus.if_req || exp_if_g) begin
        bus.if_req  = ($urandom_range(0, 3) != 0);
        bus.if_addr = ISIZE'($urandom_range(0, 31));
      end else if ($urandom_range(0, 15) == 0) begin
        bus.if_req = 1'b0;
      end
      if (!bus.d_req || exp_d_g) begin
        bus.d_req   = ($urandom_range(0, 2) != 0);
        bus.d_we    = $urandom_range(0, 1) == 1;
        bus.d_addr  = ISIZE'($urandom_range(0, 31));
        bus.d_wdata = DSIZE'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        bus.d_req = 1'b0;
      end
      cycle();
    end

    // Reset arriving the cycle after a read grant
    idle_inputs();
    rst_n = 1'b1;
    repeat (3) cycle();
    bus.d_req  = 1'b1;
    bus.d_addr = 16'h0010;
    cycle();
    idle_inputs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
